// File: rtl/clk_gen_pkg.sv
// Shared constants and helpers for the divided-clock generator.
package clk_gen_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int EDGE_W_DEF = 32;

  // A zero half-period would never toggle; it is treated as one cycle.
  function automatic logic [63:0] clamp_half(input logic [63:0] half);
    return (half == 64'd0) ? 64'd1 : half;
  endfunction
endpackage

// File: rtl/clk_gen_cfg.sv
// Holds the active and pending half-period; a pending value is applied at the
// next toggle boundary, or immediately while the generator is idle.
module clk_gen_cfg
  import clk_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HALF_PERIOD = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] cfg_half_i,
  input  logic             cfg_load_i,
  input  logic             boundary_i,
  input  logic             idle_i,
  output logic [CNT_W-1:0] half_act_o,
  output logic             idle_apply_o
);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(clamp_half(64'(HALF_PERIOD)));

  logic [CNT_W-1:0] half_act_q, half_act_d;
  logic [CNT_W-1:0] half_pend_q, half_pend_d;
  logic             pend_v_q, pend_v_d;
  logic             apply;

  always_comb begin
    apply       = pend_v_q && (boundary_i || idle_i);
    half_act_d  = half_act_q;
    half_pend_d = half_pend_q;
    pend_v_d    = pend_v_q;
    if (apply) begin
      half_act_d = half_pend_q;
      pend_v_d   = 1'b0;
    end
    // A load in the same cycle as an apply becomes the next pending value.
    if (cfg_load_i) begin
      half_pend_d = CNT_W'(clamp_half(64'(cfg_half_i)));
      pend_v_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      half_act_q  <= HALF_RST;
      half_pend_q <= HALF_RST;
      pend_v_q    <= 1'b0;
    end else begin
      half_act_q  <= half_act_d;
      half_pend_q <= half_pend_d;
      pend_v_q    <= pend_v_d;
    end
  end

  assign half_act_o   = half_act_q;
  assign idle_apply_o = apply && idle_i;
endmodule

// File: rtl/clk_gen.sv
// Divides clk into a 50%-duty square wave with registered edge strobes and a
// running transition count.
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter int HALF_PERIOD = 1,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int EDGE_W      = EDGE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_load,
  output logic              clk_out,
  output logic              rise_stb,
  output logic              fall_stb,
  output logic [EDGE_W-1:0] edge_cnt
);
  logic              en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clk_out_q, clk_out_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0]  half_act;
  logic              idle_apply;
  logic              boundary;

  // en is registered, so counting follows it by one cycle.
  assign boundary = en_q && (cnt_q == half_act - CNT_W'(1));

  clk_gen_cfg #(
    .CNT_W      (CNT_W),
    .HALF_PERIOD(HALF_PERIOD)
  ) u_cfg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_half_i  (cfg_half),
    .cfg_load_i  (cfg_load),
    .boundary_i  (boundary),
    .idle_i      (!en_q),
    .half_act_o  (half_act),
    .idle_apply_o(idle_apply)
  );

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    edge_d    = edge_q;
    if (boundary) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      rise_d    = ~clk_out_q;
      fall_d    = clk_out_q;
      edge_d    = edge_q + EDGE_W'(1);
    end else if (en_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (idle_apply) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      edge_q    <= '0;
    end else begin
      en_q      <= en;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      edge_q    <= edge_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign edge_cnt = edge_q;
endmodule

// File: tb/tb_clk_gen.sv
// Directed bench for clk_gen: four instances covering half-periods 1/3/2 and
// a 4-bit edge counter; expected levels are hand-computed per clk edge.
module tb_clk_gen;
  logic        clk = 1'b0;
  logic        rst_n    [4];
  logic        en       [4];
  logic [15:0] cfg_half [4];
  logic        cfg_load [4];
  logic        clk_out  [4];
  logic        rise_stb [4];
  logic        fall_stb [4];
  logic [31:0] ecnt     [3];
  logic [3:0]  ecnt_w4;

  int n_checks = 0;
  int n_err    = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  clk_gen #(.HALF_PERIOD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .cfg_half(cfg_half[0]),
    .cfg_load(cfg_load[0]), .clk_out(clk_out[0]), .rise_stb(rise_stb[0]),
    .fall_stb(fall_stb[0]), .edge_cnt(ecnt[0]));

  clk_gen #(.HALF_PERIOD(3)) u_h3 (
    .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .cfg_half(cfg_half[1]),
    .cfg_load(cfg_load[1]), .clk_out(clk_out[1]), .rise_stb(rise_stb[1]),
    .fall_stb(fall_stb[1]), .edge_cnt(ecnt[1]));

  clk_gen #(.HALF_PERIOD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .cfg_half(cfg_half[2]),
    .cfg_load(cfg_load[2]), .clk_out(clk_out[2]), .rise_stb(rise_stb[2]),
    .fall_stb(fall_stb[2]), .edge_cnt(ecnt[2]));

  clk_gen #(.HALF_PERIOD(1), .EDGE_W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n[3]), .en(en[3]), .cfg_half(cfg_half[3]),
    .cfg_load(cfg_load[3]), .clk_out(clk_out[3]), .rise_stb(rise_stb[3]),
    .fall_stb(fall_stb[3]), .edge_cnt(ecnt_w4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clk edges; outputs are then observed 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] outs(input int i);
    return 32'({clk_out[i], rise_stb[i], fall_stb[i]});
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; en[i] = 1'b1; cfg_half[i] = '0; cfg_load[i] = 1'b0;
    end
    tick(2);
    chk("rst_outs_h1", outs(0), 32'b000);
    chk("rst_edge_h3", ecnt[1], 32'd0);

    // Basic run, half-period 1: toggles every edge, strobes alternate.
    rst_n[0] = 1'b1;
    tick(1);
    chk("h1_e0_outs", outs(0), 32'b000);
    for (int k = 1; k <= 20; k++) begin
      logic b;
      b = (k % 2) == 1;
      exp_q.push_back({b, b, ~b});
    end
    for (int k = 1; k <= 20; k++) begin
      logic [2:0] e;
      tick(1);
      e = exp_q.pop_front();
      chk($sformatf("h1_e%0d_outs", k), outs(0), 32'(e));
    end
    chk("h1_edge20", ecnt[0], 32'd20);
    rst_n[0] = 1'b0;

    // Half-period 3: duty, count, enable gap, mid-period reset.
    rst_n[1] = 1'b1;
    tick(1);
    tick(2);  chk("h3_e2_outs", outs(1), 32'b000);
    tick(1);  chk("h3_first_rise", outs(1), 32'b110);
              chk("h3_e3_edge", ecnt[1], 32'd1);
    tick(1);  chk("h3_e4_outs", outs(1), 32'b100);
    tick(2);  chk("h3_e6_fall", outs(1), 32'b001);
    tick(6);  chk("h3_e12_fall", outs(1), 32'b001);
              chk("h3_e12_edge", ecnt[1], 32'd4);
    tick(3);  chk("h3_e15_rise", outs(1), 32'b110);
    tick(1);
    en[1] = 1'b0;
    tick(1);  chk("h3_e17_outs", outs(1), 32'b100);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("gap_outs", outs(1), 32'b100);
      chk("gap_edge", ecnt[1], 32'd5);
      if (i == 5) en[1] = 1'b1;
    end
    tick(1);  chk("gap_resume_fall", outs(1), 32'b001);
              chk("gap_resume_edge", ecnt[1], 32'd6);
    tick(3);  chk("h3_e28_rise", outs(1), 32'b110);
    cfg_load[1] = 1'b1; cfg_half[1] = 16'd5;
    tick(1);
    cfg_load[1] = 1'b0; rst_n[1] = 1'b0;
    tick(1);  chk("midrst_outs", outs(1), 32'b000);
              chk("midrst_edge", ecnt[1], 32'd0);
    rst_n[1] = 1'b1;
    tick(1);
    tick(3);  chk("postrst_rise", outs(1), 32'b110);
    tick(2);  chk("postrst_high", outs(1), 32'b100);
    tick(1);  chk("postrst_fall", outs(1), 32'b001);
              chk("postrst_edge", ecnt[1], 32'd2);
    rst_n[1] = 1'b0;

    // Half-period 2: reconfiguration timing.
    rst_n[2] = 1'b1;
    tick(1);
    tick(2);  chk("h2_first_rise", outs(2), 32'b110);
    tick(4);  chk("h2_e6_rise", outs(2), 32'b110);
    cfg_load[2] = 1'b1; cfg_half[2] = 16'd5;
    tick(1);
    cfg_load[2] = 1'b0;
    tick(1);  chk("cfg5_cur_half", outs(2), 32'b001);
    tick(4);  chk("cfg5_still_low", outs(2), 32'b000);
    tick(1);  chk("cfg5_rise", outs(2), 32'b110);
    cfg_load[2] = 1'b1; cfg_half[2] = 16'd0;
    tick(1);
    cfg_load[2] = 1'b0;
    tick(3);  chk("cfg0_high", outs(2), 32'b100);
    tick(1);  chk("cfg0_fall", outs(2), 32'b001);
    tick(1);  chk("cfg0_rise", outs(2), 32'b110);
    tick(1);  chk("cfg0_fall2", outs(2), 32'b001);
              chk("cfg0_edge", ecnt[2], 32'd8);
    // Load on a boundary cycle must not shorten/stretch the half it starts.
    cfg_load[2] = 1'b1; cfg_half[2] = 16'd3;
    tick(1);  chk("bnd_load_rise", outs(2), 32'b110);
    cfg_load[2] = 1'b0;
    tick(1);  chk("bnd_load_fall", outs(2), 32'b001);
    tick(2);  chk("cfg3_low", outs(2), 32'b000);
    tick(1);  chk("cfg3_rise", outs(2), 32'b110);
              chk("cfg3_edge", ecnt[2], 32'd11);
    // Load while disabled applies at once and clears the phase counter.
    en[2] = 1'b0;
    tick(1);
    cfg_load[2] = 1'b1; cfg_half[2] = 16'd2;
    tick(1);
    cfg_load[2] = 1'b0;
    tick(1);  chk("idle_hold", outs(2), 32'b100);
              chk("idle_edge", ecnt[2], 32'd11);
    en[2] = 1'b1;
    tick(1);
    tick(1);  chk("idle_apply_high", outs(2), 32'b100);
    tick(1);  chk("idle_apply_fall", outs(2), 32'b001);
              chk("idle_apply_edge", ecnt[2], 32'd12);
    rst_n[2] = 1'b0;

    // 4-bit edge counter wraps after 16 transitions.
    rst_n[3] = 1'b1;
    tick(1);
    tick(16); chk("wrap_e16", 32'(ecnt_w4), 32'd0);
    tick(1);  chk("wrap_e17", 32'(ecnt_w4), 32'd1);
              chk("wrap_e17_outs", outs(3), 32'b110);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/clk_gen.md
# clk_gen

Synchronous clock generator: divides the system clock into a 50%-duty square wave whose half-period is a whole number of system-clock cycles. It is the stimulus clock source for mixed-simulation benches and a generic divided-clock and strobe source in the design. Each output transition has a companion one-cycle edge strobe and a running transition count for monitors.

## Interface
- `HALF_PERIOD`, default 1: reset half-period, in `clk` cycles (≥1).
- `CNT_W`, default 16: width of the half-period counter and the `cfg_half` field.
- `EDGE_W`, default 32: width of `edge_cnt`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `en`  in  1  run enable.
- `cfg_half`  in  CNT_W  new half-period value.
- `cfg_load`  in  1  one-cycle request to latch `cfg_half`.
- `clk_out`  out  1  generated clock.
- `rise_stb`  out  1  one-cycle pulse in the cycle `clk_out` becomes 1.
- `fall_stb`  out  1  one-cycle pulse in the cycle `clk_out` becomes 0.
- `edge_cnt`  out  EDGE_W  number of `clk_out` transitions since reset.

## Operation
- Registers:
  - `cnt` (CNT_W).
  - `half_act`: active half-period.
  - `half_pend` plus a `pend_v` flag.
  - `clk_out`, strobes, `edge_cnt`.
- Reset (`rst_n`=0 at a `clk` edge):
  - `clk_out`=0, strobes=0, `edge_cnt`=0, `cnt`=0.
  - `half_act`=HALF_PERIOD, `pend_v`=0.
- Counting, while `en`=1:
  - `cnt` increments each cycle.
  - When `cnt`==`half_act`-1: `clk_out` toggles, `cnt`←0, `edge_cnt` increments (wraps modulo 2^EDGE_W), and the matching strobe asserts for exactly that cycle.
- `en`=0: `cnt`, `clk_out`, `edge_cnt` hold; strobes=0. Counting resumes from the held `cnt` when `en` returns to 1. There is no phase reset.
- Reconfiguration:
  - `cfg_load`=1 latches `cfg_half` into `half_pend` and sets `pend_v`; a later load overwrites a pending one.
  - The pending value is copied to `half_act` at the next toggle boundary, so the new value governs the following half-period.
  - If `en`=0, the pending value is applied on the next cycle and `cnt`←0.
  - `cfg_half`=0 is treated as 1.
- Simultaneous events:
  - Reset overrides everything.
  - `cfg_load` in a toggle-boundary cycle is captured as pending; it does not apply to the half-period that starts at that boundary.
  - Reset mid-period restarts cleanly at low phase.

## Timing
- `clk_out` is a registered output, so it is glitch-free.
- First rising transition occurs at the HALF_PERIOD-th `clk` edge after the first edge sampling `rst_n`=1 with `en`=1.
- Period = 2·`half_act` `clk` cycles; duty is exactly 50%.
- Strobes are registered and coincide with the cycle in which `clk_out` shows its new level.
- `HALF_PERIOD`=1 gives `clk_out` = `clk`/2.
- Latency:
  - `cfg_load` → effect at the next boundary.
  - `en` → counting one cycle later (registered sampling).

## Structure
- Package `clk_gen_pkg`: default `CNT_W`/`EDGE_W` constants and the `clamp_half` function (0→1).
- Single module.
- Optional sub-module `clk_gen_cfg` holds the pending/active half-period registers and the apply logic. The counter, toggle and strobes stay in `clk_gen`.

## Test plan
- **Basic run:** `HALF_PERIOD`=1, `en`=1, release reset, run 20 cycles → `clk_out` toggles every cycle; 20 transitions; `edge_cnt`=20; `rise_stb`/`fall_stb` alternate.
- **Duty and count:** `HALF_PERIOD`=3 → first rise 3 cycles after reset release; high 3 / low 3; `edge_cnt`=4 after 12 cycles.
- **Reconfigure:** `HALF_PERIOD`=2, `cfg_load` with `cfg_half`=5 mid-half-period → current half stays 2 cycles, next half is 5 cycles; `cfg_half`=0 → 1-cycle halves.
- **Enable gap:** deassert `en` for 7 cycles while `clk_out`=1 → level, `cnt` and `edge_cnt` frozen, no strobes; after reassert the half completes with the remaining count.
- **Reset mid-operation:** `rst_n`=0 for 1 cycle while `clk_out`=1 with `cnt`≠0 → next cycle `clk_out`=0, `edge_cnt`=0, `half_act`=HALF_PERIOD, any pending load discarded.
- **Counter wrap:** `EDGE_W`=4, 17 transitions → `edge_cnt`=1.
